subbytes_iter: RTL and testbench



---
 rtl/subbytes_iter_if.sv | 33 +++
 rtl/subbytes_iter.sv | 169 ++++++++++++++++
 tb/tb_subbytes_iter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/subbytes_iter_if.sv
// rtl/subbytes_iter_if.sv - accept/return handshake bundle for the iterative SubBytes engine
interface subbytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output inverse,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  inverse,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/subbytes_iter.sv
// rtl/subbytes_iter.sv - resource-shared AES SubBytes/InvSubBytes engine, LANES bytes per clock
module subbytes_iter #(
    parameter int LANES      = 4,
    parameter int INVERSE_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    subbytes_iter_if.slave bus
);

    localparam int STEPS = 16 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    // Byte 0 of each table sits at the most significant end of the literal.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        return SBOX_TAB[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox_f(input logic [7:0] x);
        return INV_SBOX_TAB[2047 - 8 * int'(x) -: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [127:0]    w;
    logic [127:0]    w_next;
    logic [CW-1:0]   cnt;
    logic            m;
    logic            last_step;
    int              base;
    logic [7:0]      grp [LANES];
    logic [7:0]      sub [LANES];

    assign last_step = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_step)     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so in_ready never
    // combinationally depends on out_ready or in_valid.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            RUN:  bus.busy     = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_out = w;

    // Lane mux: pick the current byte group, substitute, and write it back.
    always_comb begin
        base = int'(cnt) * LANES;
        for (int l = 0; l < LANES; l++) begin
            grp[l] = w[(base + l) * 8 +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] fwd;
        assign fwd = sbox_f(grp[l]);
        if (INVERSE_EN != 0) begin : g_inv
            assign sub[l] = m ? inv_sbox_f(grp[l]) : fwd;
        end else begin : g_fwd
            assign sub[l] = fwd;
        end
    end

    always_comb begin
        w_next = w;
        for (int l = 0; l < LANES; l++) begin
            w_next[(base + l) * 8 +: 8] = sub[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w   <= '0;
            cnt <= '0;
            m   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w   <= bus.state_in;
                        m   <= bus.inverse && (INVERSE_EN != 0);
                        cnt <= '0;
                    end
                end
                RUN: begin
                    w   <= w_next;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_iter.sv
// tb/tb_subbytes_iter.sv - directed-vector bench for subbytes_iter across lane counts
module tb_subbytes_iter;

    localparam int N = 6;
    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL_63   = {16{8'h63}};
    localparam logic [127:0] ALL_16   = {16{8'h16}};
    localparam logic [127:0] ALL_FF   = {16{8'hff}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv   [N];
    logic [127:0] din  [N];
    logic         inv  [N];
    logic         ordy [N];
    logic         irdy [N];
    logic         ov   [N];
    logic [127:0] dout [N];
    logic         bsy  [N];

    int vectors     = 0;
    int miscompares = 0;

    // Instances: 0:L4, 1:L1, 2:L2, 3:L8, 4:L16, 5:L4 forward-only
    for (genvar k = 0; k < N; k++) begin : g
        localparam int L = (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : (k == 4) ? 16 : 4;
        subbytes_iter_if bus ();
        assign bus.in_valid  = iv[k];
        assign bus.state_in  = din[k];
        assign bus.inverse   = inv[k];
        assign bus.out_ready = ordy[k];
        assign irdy[k]       = bus.in_ready;
        assign ov[k]         = bus.out_valid;
        assign dout[k]       = bus.state_out;
        assign bsy[k]        = bus.busy;
        subbytes_iter #(.LANES(L), .INVERSE_EN((k == 5) ? 0 : 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int k, input string tag);
        chk({tag, "_flags"}, 128'({irdy[k], ov[k], bsy[k]}), 128'(3'b100));
        chk({tag, "_state_out"}, dout[k], 128'd0);
    endtask

    task automatic wait_out_valid(input int k, output int lat);
        lat = 0;
        while (ov[k] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic transact(input int k, input logic [127:0] d, input logic i,
                            input logic [127:0] exp, input int lat_exp, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 128'(irdy[k]), 128'd1);
        iv[k]  = 1'b1;
        din[k] = d;
        inv[k] = i;
        @(posedge clk);
        #1;
        iv[k]  = 1'b0;
        din[k] = '0;
        inv[k] = ~i;
        chk({tag, "_busy"}, 128'({bsy[k], irdy[k]}), 128'(2'b10));
        wait_out_valid(k, lat);
        chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
        chk({tag, "_result"}, dout[k], exp);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        inv[k]  = 1'b0;
        chk({tag, "_after_hs"}, 128'({irdy[k], ov[k], bsy[k]}), 128'(3'b100));
    endtask

    initial begin
        int lat;
        int ov_seen;
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0; din[k] = '0; inv[k] = 1'b0; ordy[k] = 1'b0;
        end
        #12;
        for (int k = 0; k < N; k++) chk_idle_outputs(k, "reset");
        @(negedge clk);
        rst = 1'b0;

        transact(0, FIPS_IN,  1'b0, FIPS_OUT, 4,  "fwd_l4");
        transact(0, FIPS_OUT, 1'b1, FIPS_IN,  4,  "inv_l4");
        transact(1, FIPS_OUT, 1'b1, FIPS_IN,  16, "inv_l1");
        transact(2, FIPS_OUT, 1'b1, FIPS_IN,  8,  "inv_l2");
        transact(3, FIPS_OUT, 1'b1, FIPS_IN,  2,  "inv_l8");
        transact(4, FIPS_OUT, 1'b1, FIPS_IN,  1,  "inv_l16");
        transact(4, FIPS_IN,  1'b0, FIPS_OUT, 1,  "fwd_l16");
        transact(2, FIPS_IN,  1'b0, FIPS_OUT, 8,  "fwd_l2");

        // Backpressure: new data held on in_valid must wait for the handshake.
        @(negedge clk);
        iv[0] = 1'b1; din[0] = '0; inv[0] = 1'b0;
        @(posedge clk);
        #1;
        din[0] = ALL_FF;
        wait_out_valid(0, lat);
        chk("bp_latency", 128'(lat), 128'd4);
        for (int c = 0; c < 10; c++) begin
            inv[0] = c[0];
            chk("bp_hold_out", dout[0], ALL_63);
            chk("bp_hold_flags", 128'({irdy[0], ov[0]}), 128'(2'b01));
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        inv[0]  = 1'b0;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp_after_hs", 128'({irdy[0], ov[0]}), 128'(2'b10));
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_second_accept", 128'({bsy[0], irdy[0]}), 128'(2'b10));
        wait_out_valid(0, lat);
        chk("bp_second_latency", 128'(lat), 128'd4);
        chk("bp_second_result", dout[0], ALL_16);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;

        // Reset mid-RUN on the single-lane engine.
        @(negedge clk);
        iv[1] = 1'b1; din[1] = FIPS_IN; inv[1] = 1'b0;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("midrun_busy", 128'(bsy[1]), 128'd1);
        rst = 1'b1;
        #1;
        chk_idle_outputs(1, "midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (ov[1] === 1'b1) ov_seen++;
        end
        chk("midrun_no_out_valid", 128'(ov_seen), 128'd0);
        transact(1, FIPS_IN, 1'b0, FIPS_OUT, 16, "l1_after_rst");

        // Forward-only build ignores inverse.
        transact(5, '0,      1'b1, ALL_63,   4, "noinv_zero");
        transact(5, FIPS_IN, 1'b1, FIPS_OUT, 4, "noinv_fips");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
